// File: rtl/csr_file_m_pkg.sv
// Shared types and constants for the machine-mode CSR file: addresses, mstatus
// field positions, WARL write masks, op encoding and the difftest snapshot.
package csr_file_m_pkg;

  typedef logic [11:0] csr_addr_t;

  // Snapshot fields are fixed-width so the struct does not depend on XLEN.
  localparam int SNAP_W = 64;

  localparam csr_addr_t CSR_MSTATUS  = 12'h300;
  localparam csr_addr_t CSR_MIE      = 12'h304;
  localparam csr_addr_t CSR_MTVEC    = 12'h305;
  localparam csr_addr_t CSR_MSCRATCH = 12'h340;
  localparam csr_addr_t CSR_MEPC     = 12'h341;
  localparam csr_addr_t CSR_MCAUSE   = 12'h342;
  localparam csr_addr_t CSR_MTVAL    = 12'h343;
  localparam csr_addr_t CSR_MIP      = 12'h344;
  localparam csr_addr_t CSR_SATP     = 12'h180;
  localparam csr_addr_t CSR_MCYCLE   = 12'hB00;
  localparam csr_addr_t CSR_MINSTRET = 12'hB02;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam logic [SNAP_W-1:0] MSTATUS_RESET = 64'h0000_0000_0000_1800;

  localparam logic [SNAP_W-1:0] WMASK_FULL        = '1;
  localparam logic [SNAP_W-1:0] WMASK_MSTATUS     = 64'h0000_0000_0000_0088;
  localparam logic [SNAP_W-1:0] WMASK_MEPC        = ~64'h3;
  localparam logic [SNAP_W-1:0] WMASK_MTVEC_VEC   = ~64'h2;
  localparam logic [SNAP_W-1:0] WMASK_MTVEC_NOVEC = ~64'h3;
  localparam logic [SNAP_W-1:0] WMASK_MIP         = '0;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_SET   = 2'b10,
    OP_CLEAR = 2'b11
  } csr_op_t;

  typedef struct packed {
    logic [SNAP_W-1:0] mstatus;
    logic [SNAP_W-1:0] mie;
    logic [SNAP_W-1:0] mtvec;
    logic [SNAP_W-1:0] mscratch;
    logic [SNAP_W-1:0] mepc;
    logic [SNAP_W-1:0] mcause;
    logic [SNAP_W-1:0] mtval;
    logic [SNAP_W-1:0] mip;
    logic [SNAP_W-1:0] satp;
    logic [SNAP_W-1:0] mcycle;
    logic [SNAP_W-1:0] minstret;
  } csr_snap_t;

endpackage

// File: rtl/csr_file_m_alu.sv
// Software CSR op (write/set/clear) followed by a WARL merge: bits outside the
// mask keep their old value.
module csr_alu
  import csr_file_m_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] wd,
  input  logic [XLEN-1:0] mask,
  input  csr_op_t         op,
  output logic [XLEN-1:0] new_val
);

  logic [XLEN-1:0] raw;

  always_comb begin
    case (op)
      OP_WRITE: raw = wd;
      OP_SET:   raw = old_val | wd;
      OP_CLEAR: raw = old_val & ~wd;
      default:  raw = old_val;
    endcase
    new_val = (raw & mask) | (old_val & ~mask);
  end

endmodule

// File: rtl/csr_file_m.sv
// Machine-mode CSR file: combinational multi-port reads, masked software ops,
// free-running counters, and trap/mret state updates with a redirect target.
module csr_file_m
  import csr_file_m_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int NRP          = 2,
  parameter int RETW         = 2,
  parameter int MTVEC_VEC_EN = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NRP-1:0][11:0]      ra,
  output logic [NRP-1:0][XLEN-1:0]  rd,
  output logic [NRP-1:0]            rd_illegal,
  input  logic                      wen,
  input  logic [1:0]                wop,
  input  logic [11:0]               wa,
  input  logic [XLEN-1:0]           wd,
  input  logic [RETW-1:0]           retire_cnt,
  input  logic                      trap_valid,
  input  logic [XLEN-1:0]           trap_cause,
  input  logic [XLEN-1:0]           trap_epc,
  input  logic [XLEN-1:0]           trap_tval,
  input  logic                      mret_valid,
  output logic [XLEN-1:0]           redirect_pc,
  output csr_snap_t                 csr_snap
);

  localparam logic [XLEN-1:0] MTVEC_WMASK =
    (MTVEC_VEC_EN != 0) ? XLEN'(WMASK_MTVEC_VEC) : XLEN'(WMASK_MTVEC_NOVEC);

  logic [XLEN-1:0] mstatus_q, mstatus_d, mie_q, mie_d, mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d, mepc_q, mepc_d, mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d, satp_q, satp_d, mcycle_q, mcycle_d;
  logic [XLEN-1:0] minstret_q, minstret_d;

  logic [XLEN:0]   wa_rdata;
  logic [XLEN-1:0] alu_mask, alu_new, vec_base;
  logic            sw_we;

  // Returns {illegal, data}; mip is implemented but always reads zero.
  function automatic logic [XLEN:0] csr_read(input csr_addr_t a);
    logic [XLEN:0] r;
    r = '0;
    case (a)
      CSR_MSTATUS:  r[XLEN-1:0] = mstatus_q;
      CSR_MIE:      r[XLEN-1:0] = mie_q;
      CSR_MTVEC:    r[XLEN-1:0] = mtvec_q;
      CSR_MSCRATCH: r[XLEN-1:0] = mscratch_q;
      CSR_MEPC:     r[XLEN-1:0] = mepc_q;
      CSR_MCAUSE:   r[XLEN-1:0] = mcause_q;
      CSR_MTVAL:    r[XLEN-1:0] = mtval_q;
      CSR_MIP:      r = '0;
      CSR_SATP:     r[XLEN-1:0] = satp_q;
      CSR_MCYCLE:   r[XLEN-1:0] = mcycle_q;
      CSR_MINSTRET: r[XLEN-1:0] = minstret_q;
      default:      r[XLEN] = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [XLEN-1:0] csr_wmask(input csr_addr_t a);
    case (a)
      CSR_MSTATUS: return XLEN'(WMASK_MSTATUS);
      CSR_MEPC:    return XLEN'(WMASK_MEPC);
      CSR_MTVEC:   return MTVEC_WMASK;
      CSR_MIP:     return XLEN'(WMASK_MIP);
      default:     return XLEN'(WMASK_FULL);
    endcase
  endfunction

  always_comb begin
    rd         = '0;
    rd_illegal = '0;
    for (int p = 0; p < NRP; p++) begin
      {rd_illegal[p], rd[p]} = csr_read(ra[p]);
    end
  end

  always_comb begin
    wa_rdata = csr_read(wa);
    alu_mask = csr_wmask(wa);
    sw_we    = wen && (wop != OP_NONE) && !wa_rdata[XLEN];
  end

  csr_alu #(.XLEN(XLEN)) u_alu (
    .old_val (wa_rdata[XLEN-1:0]),
    .wd      (wd),
    .mask    (alu_mask),
    .op      (csr_op_t'(wop)),
    .new_val (alu_new)
  );

  // Next state, lowest priority first: counters, software write, mret, trap.
  always_comb begin
    mstatus_d  = mstatus_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    satp_d     = satp_q;
    mcycle_d   = mcycle_q + XLEN'(1);
    minstret_d = minstret_q + XLEN'(retire_cnt);
    if (sw_we) begin
      case (wa)
        CSR_MSTATUS:  mstatus_d  = alu_new;
        CSR_MIE:      mie_d      = alu_new;
        CSR_MTVEC:    mtvec_d    = alu_new;
        CSR_MSCRATCH: mscratch_d = alu_new;
        CSR_MEPC:     mepc_d     = alu_new;
        CSR_MCAUSE:   mcause_d   = alu_new;
        CSR_MTVAL:    mtval_d    = alu_new;
        CSR_SATP:     satp_d     = alu_new;
        CSR_MCYCLE:   mcycle_d   = alu_new;
        CSR_MINSTRET: minstret_d = alu_new;
        default: ;
      endcase
    end
    if (trap_valid) begin
      mstatus_d                = mstatus_q;
      mstatus_d[MSTATUS_MPIE]  = mstatus_q[MSTATUS_MIE];
      mstatus_d[MSTATUS_MIE]   = 1'b0;
      mepc_d                   = {trap_epc[XLEN-1:2], 2'b00};
      mcause_d                 = trap_cause;
      mtval_d                  = trap_tval;
    end else if (mret_valid) begin
      mstatus_d                = mstatus_q;
      mstatus_d[MSTATUS_MIE]   = mstatus_q[MSTATUS_MPIE];
      mstatus_d[MSTATUS_MPIE]  = 1'b1;
    end
  end

  always_comb begin
    vec_base = {mtvec_q[XLEN-1:2], 2'b00};
    if (!trap_valid) begin
      redirect_pc = mepc_q;
    end else if (trap_cause[XLEN-1] && mtvec_q[0] && (MTVEC_VEC_EN != 0)) begin
      redirect_pc = vec_base + XLEN'({trap_cause[XLEN-2:0], 2'b00});
    end else begin
      redirect_pc = vec_base;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mstatus_q  <= XLEN'(MSTATUS_RESET);
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      satp_q     <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      satp_q     <= satp_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  always_comb begin
    csr_snap          = '0;
    csr_snap.mstatus  = SNAP_W'(mstatus_q);
    csr_snap.mie      = SNAP_W'(mie_q);
    csr_snap.mtvec    = SNAP_W'(mtvec_q);
    csr_snap.mscratch = SNAP_W'(mscratch_q);
    csr_snap.mepc     = SNAP_W'(mepc_q);
    csr_snap.mcause   = SNAP_W'(mcause_q);
    csr_snap.mtval    = SNAP_W'(mtval_q);
    csr_snap.satp     = SNAP_W'(satp_q);
    csr_snap.mcycle   = SNAP_W'(mcycle_q);
    csr_snap.minstret = SNAP_W'(minstret_q);
  end

endmodule

// File: tb/tb_csr_file_m.sv
// Scoreboard bench for csr_file_m: stimulus queues expected read/redirect
// values, a negedge monitor pops and compares them.
module tb_csr_file_m;
  import csr_file_m_pkg::*;

  localparam int XLEN = 64;
  localparam int NRP  = 2;
  localparam int RETW = 2;

  localparam int K_RD = 0, K_ILL = 1, K_RPC = 2, K_SNAPC = 3;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic [NRP-1:0][11:0]     ra;
  logic [NRP-1:0][XLEN-1:0] rd;
  logic [NRP-1:0]           rd_illegal;
  logic                     wen;
  logic [1:0]               wop;
  logic [11:0]              wa;
  logic [XLEN-1:0]          wd;
  logic [RETW-1:0]          retire_cnt;
  logic                     trap_valid;
  logic [XLEN-1:0]          trap_cause, trap_epc, trap_tval;
  logic                     mret_valid;
  logic [XLEN-1:0]          redirect_pc;
  csr_snap_t                csr_snap;

  csr_file_m #(.XLEN(XLEN), .NRP(NRP), .RETW(RETW), .MTVEC_VEC_EN(1)) dut (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd), .rd_illegal(rd_illegal),
    .wen(wen), .wop(wop), .wa(wa), .wd(wd), .retire_cnt(retire_cnt),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_epc(trap_epc),
    .trap_tval(trap_tval), .mret_valid(mret_valid), .redirect_pc(redirect_pc),
    .csr_snap(csr_snap)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    int              kind;
    int              port;
    logic [XLEN-1:0] exp;
  } exp_t;

  exp_t            sb[$];
  exp_t            cur;
  logic [XLEN-1:0] act;
  int              checks = 0;
  int              failures = 0;

  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        cur = sb.pop_front();
        case (cur.kind)
          K_RD:    act = rd[cur.port];
          K_ILL:   act = XLEN'(rd_illegal[cur.port]);
          K_RPC:   act = redirect_pc;
          default: act = XLEN'(csr_snap.mcause);
        endcase
        checks++;
        if (act !== cur.exp) begin
          failures++;
          $display("FAIL %s: got 0x%0h expected 0x%0h", cur.name, act, cur.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen = 1'b0; wop = 2'b00; retire_cnt = '0;
    trap_valid = 1'b0; mret_valid = 1'b0;
  endtask

  task automatic swr(input logic [1:0] op, input logic [11:0] a, input logic [XLEN-1:0] d);
    wen = 1'b1; wop = op; wa = a; wd = d;
  endtask

  task automatic trap(input logic [XLEN-1:0] c, input logic [XLEN-1:0] e, input logic [XLEN-1:0] t);
    trap_valid = 1'b1; trap_cause = c; trap_epc = e; trap_tval = t;
  endtask

  task automatic chk(input string n, input int kind, input int port,
                     input logic [11:0] a, input logic [XLEN-1:0] e);
    if (kind == K_RD || kind == K_ILL) ra[port] = a;
    sb.push_back('{n, kind, port, e});
  endtask

  initial begin
    ra = '0; wa = '0; wd = '0;
    trap_cause = '0; trap_epc = '0; trap_tval = '0;
    idle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    chk("rst_mstatus", K_RD, 0, 12'h300, 64'h1800);
    chk("rst_legal", K_ILL, 0, 12'h300, 64'd0);
    chk("rst_unimpl_rd", K_RD, 1, 12'h7C0, 64'd0);
    chk("rst_unimpl_flag", K_ILL, 1, 12'h7C0, 64'd1);
    chk("rst_redirect", K_RPC, 0, 12'h0, 64'd0);
    repeat (5) step();
    chk("mcycle_5", K_RD, 0, 12'hB00, 64'd5);

    step(); swr(OP_WRITE, 12'h340, 64'hF0); chk("ms_write_same_cycle", K_RD, 0, 12'h340, 64'h0);
    step(); swr(OP_SET,   12'h340, 64'h0F); chk("ms_write", K_RD, 0, 12'h340, 64'hF0);
    step(); swr(OP_CLEAR, 12'h340, 64'h3C); chk("ms_set", K_RD, 0, 12'h340, 64'hFF);
    step(); swr(OP_NONE,  12'h340, 64'h0);  chk("ms_clear", K_RD, 0, 12'h340, 64'hC3);
    step(); swr(OP_WRITE, 12'h7C0, 64'h1234); chk("ms_nop_op", K_RD, 0, 12'h340, 64'hC3);

    step(); swr(OP_WRITE, 12'h341, 64'h8000_0003);
    chk("unimpl_after_write", K_RD, 1, 12'h7C0, 64'd0);
    step(); swr(OP_WRITE, 12'h300, '1);
    step(); swr(OP_WRITE, 12'h344, 64'hFFFF); chk("mepc_mask", K_RD, 0, 12'h341, 64'h8000_0000);
    step(); idle(); chk("mstatus_mask", K_RD, 0, 12'h300, 64'h1888);
    chk("redirect_mepc", K_RPC, 0, 12'h0, 64'h8000_0000);
    step(); chk("mip_ro", K_RD, 0, 12'h344, 64'd0);

    step(); retire_cnt = 2'd3; chk("minstret_0", K_RD, 1, 12'hB02, 64'd0);
    repeat (4) step();
    retire_cnt = '0; chk("minstret_12", K_RD, 1, 12'hB02, 64'd12);

    step(); swr(OP_WRITE, 12'hB00, '1);
    step(); idle(); chk("mcycle_max", K_RD, 0, 12'hB00, '1);
    step(); swr(OP_WRITE, 12'hB00, 64'd100); chk("mcycle_wrap", K_RD, 0, 12'hB00, 64'd0);
    step(); idle(); chk("mcycle_write_wins", K_RD, 0, 12'hB00, 64'd100);
    step(); chk("mcycle_inc", K_RD, 0, 12'hB00, 64'd101);

    step(); swr(OP_WRITE, 12'h300, 64'h8);
    step(); swr(OP_WRITE, 12'h305, 64'h1001); chk("mstatus_mie_only", K_RD, 0, 12'h300, 64'h1808);
    step(); idle(); trap(64'h8000_0000_0000_0007, 64'h2002, 64'h55);
    chk("mtvec_vec", K_RD, 0, 12'h305, 64'h1001);
    chk("redirect_vectored", K_RPC, 0, 12'h0, 64'h101C);
    step(); idle();
    chk("trap_mepc", K_RD, 0, 12'h341, 64'h2000);
    chk("trap_mstatus", K_RD, 1, 12'h300, 64'h1880);
    chk("redirect_after_trap", K_RPC, 0, 12'h0, 64'h2000);
    chk("snap_mcause", K_SNAPC, 0, 12'h0, 64'h8000_0000_0000_0007);
    step(); mret_valid = 1'b1;
    chk("trap_mtval", K_RD, 0, 12'h343, 64'h55);
    chk("mret_redirect", K_RPC, 0, 12'h0, 64'h2000);
    step(); idle(); chk("mret_mstatus", K_RD, 1, 12'h300, 64'h1888);

    step(); trap(64'd2, 64'h3000, 64'd0); mret_valid = 1'b1;
    swr(OP_WRITE, 12'h340, 64'd5);
    chk("coll_redirect_exc", K_RPC, 0, 12'h0, 64'h1000);
    step(); idle();
    chk("coll_mscratch", K_RD, 0, 12'h340, 64'd5);
    chk("coll_mstatus", K_RD, 1, 12'h300, 64'h1880);
    step();
    chk("coll_mepc", K_RD, 0, 12'h341, 64'h3000);
    chk("coll_mcause", K_RD, 1, 12'h342, 64'd2);

    step(); swr(OP_WRITE, 12'h340, 64'h77);
    #1 reset = 1'b0;
    chk("arst_mscratch", K_RD, 0, 12'h340, 64'd0);
    chk("arst_mstatus", K_RD, 1, 12'h300, 64'h1800);
    step(); idle(); reset = 1'b1;
    chk("arst_mscratch_hold", K_RD, 0, 12'h340, 64'd0);
    chk("arst_mcycle", K_RD, 1, 12'hB00, 64'd0);

    step(); step();
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csr_file_m.md
Name: csr_file_m

Overview:
Parametrised machine-mode CSR file, replacing the flat 32-entry CSR array. Decodes full 12-bit CSR addresses. Supports atomic write/set/clear ops with per-register WARL masks, free-running mcycle, multi-retire minstret, and trap-entry/mret state updates. Sits in the pipeline beside the GPR file: ID/EX reads it, WB/commit writes and signals traps.

Parameters:
XLEN, 64, data width of every CSR
NRP, 2, number of combinational read ports
RETW, 2, width of retire count input (max retire per cycle = 2**RETW-1)
MTVEC_VEC_EN, 1, 1 = honour mtvec.MODE=1 vectored interrupts; 0 = MODE bits read 0

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-low (asserted at 0)
ra  in  NRP x 12  read addresses
rd  out  NRP x XLEN  read data, combinational from current state
rd_illegal  out  NRP  address not implemented
wen  in  1  software CSR access commit
wop  in  2  00 none, 01 write, 10 set, 11 clear
wa  in  12  write address
wd  in  XLEN  source operand
retire_cnt  in  RETW  instructions retired this cycle
trap_valid  in  1  take trap this cycle
trap_cause  in  XLEN  mcause value (bit XLEN-1 = interrupt)
trap_epc  in  XLEN  faulting PC
trap_tval  in  XLEN  mtval value
mret_valid  in  1  execute mret this cycle
redirect_pc  out  XLEN  trap vector when trap_valid, else mepc
csr_snap  out  csr_snap_t  all implemented CSRs, registered state (difftest)

Behaviour:
- Implemented CSRs: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344, satp 0x180, mcycle 0xB00, minstret 0xB02.
- Unimplemented address: rd=0, rd_illegal=1. Writes to it are ignored.
- Reset (reset=0, async): all CSRs 0 except mstatus.MPP=2'b11. Outputs follow state immediately.
- Reads: combinational, no write bypass. A write is visible on the cycle after commit.
- Op value: write new=wd; set new=old|wd; clear new=old&~wd. Then stored = (new&mask)|(old&~mask).
- Write masks:
  - mstatus: MIE[3], MPIE[7] writable; MPP fixed 11.
  - mepc: [1:0] forced 0.
  - mtvec: [1] reads 0; [0] forced 0 when MTVEC_VEC_EN=0.
  - mip: read-only 0 (writes ignored).
  - Others: fully writable.
- wen=1 with wop=00 writes nothing.
- mcycle: +1 every cycle, wraps at 2**XLEN-1 -> 0.
- minstret: += retire_cnt, mod 2**XLEN.
- Same-cycle software write to mcycle or minstret wins; no increment that cycle.
- Trap (trap_valid=1), applied at clock edge:
  - mepc=trap_epc&~3, mcause=trap_cause, mtval=trap_tval
  - MPIE=MIE, MIE=0
- mret (mret_valid=1), applied at clock edge: MIE=MPIE, MPIE=1.
- Priority: trap > mret > software write, per register.
  - Trap updates only its listed fields; a software write in the same cycle to any other CSR still commits.
  - trap_valid and mret_valid both set: trap only.
- redirect_pc:
  - trap_valid, interrupt (cause MSB=1) and mtvec.MODE=1: base + 4*cause[XLEN-2:0].
  - trap_valid otherwise: base.
  - trap_valid=0: mepc.
  - base = mtvec & ~3. Addition wraps mod 2**XLEN.
- Reset mid-operation: all pending effects are discarded; state returns to reset values.

Decomposition:
- Shared package: csr_addr_t (12 bits), CSR address constants, mstatus bit-index constants, per-CSR write-mask constants, csr_op_t enum, csr_snap_t struct.
- One sub-module: csr_alu, combinational op plus WARL mask merge (old, wd, op, mask -> new).

Test Plan:
- Reset: hold reset=0, then release. Read 0x300 -> 0x1800; mcycle after 5 cycles -> 5; read 0x7C0 -> rd=0, rd_illegal=1.
- Op semantics on mscratch:
  - write 0xF0 -> 0xF0
  - set 0x0F -> 0xFF
  - clear 0x3C -> 0xC3
  - each value visible next cycle, not same cycle.
- WARL masks:
  - write mepc=0x8000_0003 -> reads 0x8000_0000
  - write mstatus=all-ones -> reads 0x1888
  - write mip=0xFFFF -> reads 0.
- Counters:
  - retire_cnt=3 for 4 cycles -> minstret +12.
  - mcycle=2**XLEN-1 -> wraps to 0 next cycle.
  - write mcycle=100 with a same-cycle increment -> reads 100, then 101.
- Trap/mret: MIE=1, mtvec=0x1001 (vectored), trap cause=0x8000_0000_0000_0007, epc=0x2002:
  - redirect_pc=0x101C same cycle
  - next cycle: mepc=0x2000, MIE=0, MPIE=1
  - then mret -> MIE=1, MPIE=1, redirect_pc=0x2000.
- Collision: trap_valid+mret_valid+software write to mscratch=5 in one cycle -> trap effects only on status/epc/cause; mscratch=5.
